random_multi: RTL

- Multi-channel pseudo-random number peripheral. It is the parametrised successor of the single-channel random device and sits on the same simple read/write peripheral bus.
- Provides CHANNELS independent Galois LFSR generators. Each has a configurable width, tap mask and reset seed, and can be reseeded by software.
- Each channel either free-runs every cycle or advances only when it is read, selected by a mode parameter.
- Registered bus interface with fixed 2-cycle read latency.

---
 rtl/random_pkg.sv | 17 +
 rtl/random_lfsr_channel.sv | 45 ++++
 rtl/random_multi.sv | 102 ++++++++++
 3 files changed

// File: rtl/random_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// random_pkg : shared types and limits for the random_multi peripheral
// Rev 1.0
//------------------------------------------------------------------------------
package random_pkg;

   typedef enum logic [0:0] {
      RNG_FREE_RUN = 1'b0,
      RNG_ON_READ  = 1'b1
   } rng_mode_t;

   localparam int RNG_MIN_WIDTH = 8;
   localparam int RNG_MAX_WIDTH = 64;

endpackage
`default_nettype wire

// File: rtl/random_lfsr_channel.sv
`default_nettype none
//------------------------------------------------------------------------------
// random_lfsr_channel : one reseedable Galois LFSR generator
// Rev 1.0
//------------------------------------------------------------------------------
module random_lfsr_channel #(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] TAPS  = 32'h80200003,
   parameter logic [WIDTH-1:0] INIT  = 32'hACE12468
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             step,
   output logic [WIDTH-1:0] state
);

   // An all-zero state would lock the LFSR, so zero is replaced by 1.
   localparam logic [WIDTH-1:0] INIT_NZ = (INIT == '0) ? WIDTH'(1) : INIT;

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = (seed == '0) ? WIDTH'(1) : seed;
      end else if (step) begin
         state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT_NZ;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/random_multi.sv
`default_nettype none
//------------------------------------------------------------------------------
// random_multi : multi-channel LFSR random number peripheral, 2-cycle reads
// Rev 1.0
//------------------------------------------------------------------------------
module random_multi
   import random_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter int               CHANNELS   = 4,
   parameter int               AW         = 4,
   parameter logic [WIDTH-1:0] TAPS       = 32'h80200003,
   parameter logic [WIDTH-1:0] RESET_SEED = 32'hACE12468,
   parameter rng_mode_t        MODE       = RNG_ON_READ
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             read,
   input  logic             write,
   input  logic [AW-1:0]    address,
   input  logic [WIDTH-1:0] dataIn,
   output logic             readValid,
   output logic [WIDTH-1:0] dataOut
);

   if ((1 << AW) < CHANNELS) begin : g_chk_aw
      $error("random_multi: AW too small for CHANNELS");
   end
   if ((WIDTH < RNG_MIN_WIDTH) || (WIDTH > RNG_MAX_WIDTH)) begin : g_chk_width
      $error("random_multi: WIDTH out of supported range");
   end

   logic             read_q, read_d;
   logic             write_q, write_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [WIDTH-1:0] data_in_q, data_in_d;
   logic             read_valid_q, read_valid_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;

   logic [WIDTH-1:0]    chan_state [CHANNELS];
   logic [CHANNELS-1:0] chan_load;
   logic [CHANNELS-1:0] chan_step;

   always_comb begin
      read_d       = read;
      write_d      = write;
      addr_d       = address;
      data_in_d    = dataIn;
      read_valid_d = read_q;
      data_out_d   = data_out_q;
      // Unmatched (out-of-range) addresses fall through to zero.
      if (read_q) begin
         data_out_d = '0;
         for (int i = 0; i < CHANNELS; i++) begin
            if (addr_q == AW'(i)) begin
               data_out_d = chan_state[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      addr_q    <= addr_d;
      data_in_q <= data_in_d;
      if (reset) begin
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         read_valid_q <= 1'b0;
         data_out_q   <= '0;
      end else begin
         read_q       <= read_d;
         write_q      <= write_d;
         read_valid_q <= read_valid_d;
         data_out_q   <= data_out_d;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      localparam logic [WIDTH-1:0] CHAN_INIT = RESET_SEED ^ WIDTH'(g);

      assign chan_load[g] = write_q && (addr_q == AW'(g));
      assign chan_step[g] = (MODE == RNG_FREE_RUN) || (read_q && (addr_q == AW'(g)));

      random_lfsr_channel #(
         .WIDTH (WIDTH),
         .TAPS  (TAPS),
         .INIT  (CHAN_INIT)
      ) u_chan (
         .clk   (clk),
         .reset (reset),
         .load  (chan_load[g]),
         .seed  (data_in_q),
         .step  (chan_step[g]),
         .state (chan_state[g])
      );
   end

   assign readValid = read_valid_q;
   assign dataOut   = data_out_q;

endmodule
`default_nettype wire
